// File: rtl/gamma_lut_arbiter_pkg.sv
// gamma_pkg: constants and tag type shared by the gamma LUT arbiter slice.
// Optional feature macro used by this slice: GAMMA_BYPASS_EN.
package gamma_pkg;

    localparam int LUT_AW          = 8;
    localparam int LUT_DW          = 8;
    localparam int LUT_LAT_DEFAULT = 2;

    // Tag id is sized for the largest supported requester count (8) so one
    // struct type serves every parameterisation; the top uses the low ID_W bits.
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                bypass;
    } tag_t;

endpackage

// File: rtl/gamma_lut_arbiter_if.sv
// Request, response and LUT buses of the gamma LUT arbiter.
// slave = arbiter side, master = producers / LUT / consumer side.
interface gamma_lut_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    import gamma_pkg::*;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [LUT_DW*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [LUT_AW-1:0]         lut_addr_o;
    logic [LUT_DW-1:0]         lut_data_i;
    logic                      rsp_valid_o;
    logic [ID_W-1:0]           rsp_id_o;
    logic [LUT_DW-1:0]         rsp_data_o;

    modport slave (
        input  req_valid_i, req_data_i, lut_data_i,
        output req_ready_o, lut_addr_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_data_i, lut_data_i,
        input  req_ready_o, lut_addr_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );

endinterface

// File: rtl/gamma_lut_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant generator.
// Searches last+1, last+2, ... (mod NUM_REQ) and grants the first active request.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_grant_any
);

    int w_idx;

    // Rotating priority search starting just after the last granted index.
    always_comb begin
        o_grant     = '0;
        o_grant_id  = '0;
        o_grant_any = 1'b0;
        w_idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(i_last) + i) % NUM_REQ;
            if (!o_grant_any && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_id     = ID_W'(w_idx);
                o_grant_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gamma_lut_arbiter.sv
// gamma_lut_arbiter: shares one gamma LUT among NUM_REQ block-mean producers.
// One lookup per cycle, round-robin granted, tagged with the requester index
// and returned on a shared response bus LUT_LAT+1 clocks after the grant.
// The LUT is expected to present lut_data_i LUT_LAT clocks after the grant
// edge that loads lut_addr_o, i.e. in the cycle before the response.
// Optional feature: define GAMMA_BYPASS_EN to add bypass_i, which returns the
// raw request value instead of the LUT output for lookups tagged at grant.
module gamma_lut_arbiter
    import gamma_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LUT_LAT = LUT_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                frame_start_i,
`ifdef GAMMA_BYPASS_EN
    input  logic                bypass_i,
`endif
    gamma_lut_arbiter_if.slave  bus
);

    logic [ID_W-1:0]    r_last;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_grant_any;
    logic [LUT_DW-1:0]  w_grant_data;
    logic               w_bypass;
    tag_t               w_tag_in;
    tag_t               r_tag [LUT_LAT];
    logic [LUT_AW-1:0]  r_lut_addr;
    logic [LUT_DW-1:0]  w_rsp_data_src;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [LUT_DW-1:0]  r_rsp_data;
    logic               w_unused_tag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid_i),
        .i_last      (r_last),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_grant_any (w_grant_any)
    );

    assign bus.req_ready_o = w_grant;
    assign w_grant_data    = bus.req_data_i[int'(w_grant_id)*LUT_DW +: LUT_DW];

`ifdef GAMMA_BYPASS_EN
    assign w_bypass = bypass_i;
`else
    assign w_bypass = 1'b0;
`endif

    // Stage-0 tag for this cycle's grant (valid low when nothing is granted).
    always_comb begin
        w_tag_in        = '0;
        w_tag_in.valid  = w_grant_any;
        w_tag_in.id     = TAG_ID_W'(w_grant_id);
        w_tag_in.bypass = w_bypass;
    end

    // Round-robin pointer; frame start wins over a same-cycle grant update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= ID_W'(NUM_REQ - 1);
        end else if (frame_start_i) begin
            r_last <= ID_W'(NUM_REQ - 1);
        end else if (w_grant_any) begin
            r_last <= w_grant_id;
        end
    end

    // LUT address register: loads the granted request value, else holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lut_addr <= '0;
        end else if (w_grant_any) begin
            r_lut_addr <= w_grant_data;
        end
    end

    assign bus.lut_addr_o = r_lut_addr;

    // Tag shift register, stages 0..LUT_LAT-1; the response registers form the final stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LUT_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < LUT_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

`ifdef GAMMA_BYPASS_EN
    logic [LUT_DW-1:0] r_dpipe [LUT_LAT];

    // Raw request value travelling alongside the tag; stage 0 mirrors the
    // address register so the address path is identical in both builds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LUT_LAT; i++) begin
                r_dpipe[i] <= '0;
            end
        end else begin
            if (w_grant_any) begin
                r_dpipe[0] <= w_grant_data;
            end
            for (int i = 1; i < LUT_LAT; i++) begin
                r_dpipe[i] <= r_dpipe[i-1];
            end
        end
    end

    assign w_rsp_data_src = r_tag[LUT_LAT-1].bypass ? r_dpipe[LUT_LAT-1] : bus.lut_data_i;
`else
    assign w_rsp_data_src = bus.lut_data_i;
`endif

    // Final stage: id and data only update on a valid response, so they hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_tag[LUT_LAT-1].valid;
            if (r_tag[LUT_LAT-1].valid) begin
                r_rsp_id   <= r_tag[LUT_LAT-1].id[ID_W-1:0];
                r_rsp_data <= w_rsp_data_src;
            end
        end
    end

    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_data_o  = r_rsp_data;

    // Tag bits beyond ID_W (and bypass in the default build) are intentionally unread.
    assign w_unused_tag = ^{r_tag[LUT_LAT-1]};

endmodule

// File: tb/tb_gamma_lut_arbiter.sv
// Directed bench for gamma_lut_arbiter with a one-register LUT model
// (data appears LUT_LAT=2 clocks after the grant edge).
module tb_gamma_lut_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       frame_start;
    logic       bypass;
    logic [7:0] lut_q;
    int         total = 0;
    int         bad   = 0;

    gamma_lut_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    gamma_lut_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2),
        .LUT_LAT (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .frame_start_i (frame_start),
        .bus           (bus)
`ifdef GAMMA_BYPASS_EN
        ,.bypass_i     (bypass)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lut_f(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hA5;
    endfunction

    always @(posedge clk) lut_q <= lut_f(bus.lut_addr_o);
    assign bus.lut_data_i = lut_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [7:0] data);
        check({tag, "_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        check({tag, "_id"},    32'(bus.rsp_id_o),    32'(id));
        check({tag, "_data"},  32'(bus.rsp_data_o),  32'(data));
    endtask

    initial begin
        rstn            = 1'b0;
        frame_start     = 1'b0;
        bypass          = 1'b0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        mid();
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id_o),    32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data_o),  32'd0);
        check("rst_lut_addr",  32'(bus.lut_addr_o),  32'd0);
        check("rst_ready",     32'(bus.req_ready_o), 32'd0);
        next_cycle();
        rstn = 1'b1;

        // Single requester 2, data 0x40
        next_cycle();
        bus.req_valid_i = 4'b0100;
        bus.req_data_i  = 32'h0040_0000;
        mid();
        check("single_ready", 32'(bus.req_ready_o), 32'h4);
        next_cycle();
        bus.req_valid_i = '0;
        mid();
        check("single_addr",    32'(bus.lut_addr_o),  32'h40);
        check("single_nrsp_c1", 32'(bus.rsp_valid_o), 32'd0);
        next_cycle();
        mid();
        check("single_nrsp_c2", 32'(bus.rsp_valid_o), 32'd0);
        next_cycle();
        mid();
        check_rsp("single_rsp", 2'd2, lut_f(8'h40));

        // All four valid from reset: 0,1,2,3,0,... and back-to-back responses
        next_cycle();
        rstn = 1'b0;
        #1;
        check("rst2_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        next_cycle();
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            if (i == 0) begin
                bus.req_valid_i = 4'b1111;
                bus.req_data_i  = 32'h4433_2211;
            end
            if (i == 8) bus.req_valid_i = '0;
            mid();
            if (i < 8) check($sformatf("all_ready_%0d", i), 32'(bus.req_ready_o), 32'd1 << (i % 4));
            if (i >= 3 && i <= 10) begin
                check_rsp($sformatf("all_rsp_%0d", i), 2'((i - 3) % 4),
                          lut_f(8'(8'h11 * (((i - 3) % 4) + 1))));
            end else begin
                check($sformatf("all_nrsp_%0d", i), 32'(bus.rsp_valid_o), 32'd0);
            end
        end
        check("hold_id",   32'(bus.rsp_id_o),   32'd3);
        check("hold_data", 32'(bus.rsp_data_o), 32'(lut_f(8'h44)));

        // Set last=1, then requesters 1 and 3: 3,1,3,1
        next_cycle();
        bus.req_valid_i = 4'b0010;
        bus.req_data_i  = 32'h6600_5500;
        mid();
        check("set1_ready", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        bus.req_valid_i = '0;
        next_cycle();
        next_cycle();
        mid();
        check_rsp("set1_rsp", 2'd1, lut_f(8'h55));
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.req_valid_i = 4'b1010;
            mid();
            check($sformatf("alt_ready_%0d", i), 32'(bus.req_ready_o), (i % 2 == 0) ? 32'h8 : 32'h2);
        end

        // frame_start behaviour
        next_cycle();
        bus.req_valid_i = 4'b0100;
        bus.req_data_i  = 32'h0077_0000;
        mid();
        check("fs_set2_ready", 32'(bus.req_ready_o), 32'h4);
        next_cycle();
        bus.req_valid_i = 4'b1111;
        frame_start     = 1'b1;
        mid();
        check("fs_grant3", 32'(bus.req_ready_o), 32'h8);
        next_cycle();
        frame_start = 1'b0;
        mid();
        check("fs_grant0", 32'(bus.req_ready_o), 32'h1);
        next_cycle();
        bus.req_valid_i = 4'b0110;
        frame_start     = 1'b1;
        mid();
        check("fs_prec_grant1", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        frame_start = 1'b0;
        mid();
        check("fs_prec_regrant1", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        bus.req_valid_i = '0;
        frame_start     = 1'b1;
        mid();
        check("fs_idle_ready", 32'(bus.req_ready_o), 32'h0);
        next_cycle();
        frame_start     = 1'b0;
        bus.req_valid_i = 4'b1001;
        mid();
        check("fs_idle_grant0", 32'(bus.req_ready_o), 32'h1);
        next_cycle();
        bus.req_valid_i = '0;
        repeat (4) next_cycle();

        // Burst of three grants, then reset mid-flight
        bus.req_valid_i = 4'b0111;
        bus.req_data_i  = 32'h0033_2211;
        mid();
        check("burst_g1", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        mid();
        check("burst_g2", 32'(bus.req_ready_o), 32'h4);
        next_cycle();
        mid();
        check("burst_g0", 32'(bus.req_ready_o), 32'h1);
        next_cycle();
        bus.req_valid_i = '0;
        mid();
        check_rsp("burst_rsp1", 2'd1, lut_f(8'h22));
        next_cycle();
        rstn = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("midrst_addr",  32'(bus.lut_addr_o),  32'd0);
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            check($sformatf("postrst_nrsp_%0d", i), 32'(bus.rsp_valid_o), 32'd0);
            next_cycle();
        end
        bus.req_valid_i = 4'b1010;
        bus.req_data_i  = 32'h4400_2200;
        mid();
        check("postrst_grant1", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        bus.req_valid_i = '0;
        next_cycle();
        mid();
        check("postrst_nrsp_c2", 32'(bus.rsp_valid_o), 32'd0);
        next_cycle();
        mid();
        check_rsp("postrst_rsp", 2'd1, lut_f(8'h22));

`ifdef GAMMA_BYPASS_EN
        // Bypass lookup followed by a normal lookup
        next_cycle();
        bus.req_valid_i = 4'b0001;
        bus.req_data_i  = 32'h0000_007F;
        bypass          = 1'b1;
        mid();
        check("byp_ready0", 32'(bus.req_ready_o), 32'h1);
        next_cycle();
        bus.req_data_i = 32'h0000_0030;
        bypass         = 1'b0;
        mid();
        check("byp_ready1", 32'(bus.req_ready_o), 32'h1);
        next_cycle();
        bus.req_valid_i = '0;
        next_cycle();
        mid();
        check_rsp("byp_rsp_raw", 2'd0, 8'h7F);
        next_cycle();
        mid();
        check_rsp("byp_rsp_lut", 2'd0, lut_f(8'h30));
`endif

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
